// File: rtl/san_cnt_sched.sv
// Job scheduler for the san_cnt counter: queues (load, tag) jobs, programs the
// counter, waits for its IRQ edge or a timeout, clears it and reports completion.
module san_cnt_sched #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESET,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_data,
  input  logic [1:0]               req_id,
  input  logic                     abort,
  output logic                     slv_reg_wren,
  output logic [2:0]               axi_awaddr,
  output logic [31:0]              S_AXI_WDATA,
  input  logic                     EXT_IRQ,
  output logic                     done_valid,
  output logic [1:0]               done_id,
  output logic                     done_timeout,
  output logic                     done_abort,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   q_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CLEAR,
    S_REPORT
  } state_t;

  state_t          state, state_nx;
  logic [33:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [33:0]     head;
  logic            rdy_en, push, pop, full;
  logic            irq_q, irq_edge, tmo_hit;
  logic [TW-1:0]   timer;
  logic [1:0]      id_q;
  logic            to_q, ab_q, set_to, set_ab;

  assign full      = (q_level == FULL_LVL);
  assign req_ready = rdy_en & ~full & ~abort;
  assign push      = req_valid & req_ready;
  assign head      = mem[rd_ptr];
  assign irq_edge  = EXT_IRQ & ~irq_q;
  assign tmo_hit   = (timer == TMO_LAST);

  assign slv_reg_wren = (state == S_LOAD) || (state == S_CLEAR);
  assign done_valid   = (state == S_REPORT);
  assign busy         = (state != S_IDLE);
  assign done_id      = id_q;
  assign done_timeout = to_q;
  assign done_abort   = ab_q;

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    set_to   = 1'b0;
    set_ab   = 1'b0;
    case (state)
      S_IDLE: begin
        // an abort in IDLE only flushes; it must not launch the head job
        if ((q_level != '0) && !abort) begin
          state_nx = S_LOAD;
          pop      = 1'b1;
        end
      end
      S_LOAD: begin
        state_nx = abort ? S_CLEAR : S_WAIT;
        set_ab   = abort;
      end
      S_WAIT: begin
        if (abort) begin
          state_nx = S_CLEAR;
          set_ab   = 1'b1;
        end else if (irq_edge) begin
          state_nx = S_CLEAR;
        end else if (tmo_hit) begin
          state_nx = S_CLEAR;
          set_to   = 1'b1;
        end
      end
      S_CLEAR:  state_nx = S_REPORT;
      S_REPORT: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (push) mem[wr_ptr] <= {req_id, req_data};
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state       <= S_IDLE;
      rdy_en      <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      q_level     <= '0;
      irq_q       <= 1'b0;
      timer       <= '0;
      id_q        <= '0;
      to_q        <= 1'b0;
      ab_q        <= 1'b0;
      axi_awaddr  <= '0;
      S_AXI_WDATA <= '0;
    end else begin
      state  <= state_nx;
      rdy_en <= 1'b1;
      irq_q  <= EXT_IRQ;

      if (abort) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        q_level <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        q_level <= q_level + CW'(push) - CW'(pop);
      end

      if (state == S_LOAD)      timer <= '0;
      else if (state == S_WAIT) timer <= timer + 1'b1;

      if (pop) begin
        id_q <= head[33:32];
        to_q <= 1'b0;
        ab_q <= 1'b0;
      end
      if (set_to) to_q <= 1'b1;
      if (set_ab) ab_q <= 1'b1;

      // address/data are registered against the next state so they hold between writes
      if (state_nx == S_LOAD) begin
        axi_awaddr  <= 3'd0;
        S_AXI_WDATA <= head[31:0];
      end else if (state_nx == S_CLEAR) begin
        axi_awaddr  <= 3'd4;
        S_AXI_WDATA <= '0;
      end
    end
  end

endmodule

// File: tb/tb_san_cnt_sched.sv
// Directed self-checking bench for san_cnt_sched.
module tb_san_cnt_sched;
  localparam int DEPTH = 4;
  localparam int TMO   = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_data = '0;
  logic [1:0]  req_id = '0;
  logic        abort = 1'b0;
  logic        slv_reg_wren;
  logic [2:0]  axi_awaddr;
  logic [31:0] wdata;
  logic        ext_irq = 1'b0;
  logic        done_valid;
  logic [1:0]  done_id;
  logic        done_timeout, done_abort, busy;
  logic [2:0]  q_level;

  int errors = 0;
  int checks = 0;

  san_cnt_sched #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_id(req_id),
    .abort(abort), .slv_reg_wren(slv_reg_wren), .axi_awaddr(axi_awaddr), .S_AXI_WDATA(wdata),
    .EXT_IRQ(ext_irq), .done_valid(done_valid), .done_id(done_id),
    .done_timeout(done_timeout), .done_abort(done_abort), .busy(busy), .q_level(q_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // advance until a LOAD strobe is visible, bounded
  task automatic wait_load(input string tag);
    int n = 0;
    while (!(slv_reg_wren && axi_awaddr == 3'd0) && n < 20) begin
      cyc();
      n++;
    end
    chk(tag, {31'd0, slv_reg_wren}, 32'd1);
  endtask

  task automatic push1(input logic [1:0] id, input logic [31:0] d);
    req_valid = 1'b1; req_id = id; req_data = d;
    chk("push_ready", {31'd0, req_ready}, 32'd1);
    cyc();
    req_valid = 1'b0;
  endtask

  initial begin
    int seen;
    // reset state
    #2;
    chk("rst_ready", {31'd0, req_ready}, 0);
    chk("rst_wren", {31'd0, slv_reg_wren}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_lvl", {29'd0, q_level}, 0);
    chk("rst_done", {31'd0, done_valid}, 0);
    chk("rst_addr", {29'd0, axi_awaddr}, 0);
    chk("rst_wdata", wdata, 0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("post_rst_ready", {31'd0, req_ready}, 1);

    // single job: LOAD two cycles after acceptance, IRQ 20 cycles after LOAD
    push1(2'd2, 32'd100);
    chk("s_lvl", {29'd0, q_level}, 1);
    chk("s_idle", {31'd0, busy}, 0);
    cyc();
    chk("s_load_wren", {31'd0, slv_reg_wren}, 1);
    chk("s_load_addr", {29'd0, axi_awaddr}, 0);
    chk("s_load_data", wdata, 100);
    chk("s_busy", {31'd0, busy}, 1);
    repeat (20) cyc();
    chk("s_wait_nowren", {31'd0, slv_reg_wren}, 0);
    ext_irq = 1'b1;
    cyc();
    chk("s_clr_wren", {31'd0, slv_reg_wren}, 1);
    chk("s_clr_addr", {29'd0, axi_awaddr}, 4);
    chk("s_clr_data", wdata, 0);
    chk("s_clr_nodone", {31'd0, done_valid}, 0);
    ext_irq = 1'b0;
    cyc();
    chk("s_done", {31'd0, done_valid}, 1);
    chk("s_done_id", {30'd0, done_id}, 2);
    chk("s_done_to", {31'd0, done_timeout}, 0);
    chk("s_done_ab", {31'd0, done_abort}, 0);
    chk("s_addr_hold", {29'd0, axi_awaddr}, 4);
    cyc();
    chk("s_back_idle", {31'd0, busy}, 0);
    chk("s_done_pulse", {31'd0, done_valid}, 0);

    // queue fill: one job in flight plus DEPTH queued, then ready drops
    for (int i = 0; i < 5; i++) push1(2'(i % 4), 32'(10 + i));
    chk("f_full_lvl", {29'd0, q_level}, 4);
    chk("f_full_ready", {31'd0, req_ready}, 0);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) begin
        wait_load("f_load");
        chk("f_data", wdata, 32'(10 + j));
        chk("f_lvl", {29'd0, q_level}, 32'(4 - j));
        cyc();
      end
      ext_irq = 1'b1;
      cyc();
      chk("f_clr_addr", {29'd0, axi_awaddr}, 4);
      ext_irq = 1'b0;
      cyc();
      chk("f_done", {31'd0, done_valid}, 1);
      chk("f_done_id", {30'd0, done_id}, 32'(j % 4));
    end
    cyc();
    chk("f_ready_back", {31'd0, req_ready}, 1);

    // timeout with a zero load value
    push1(2'd1, 32'd0);
    cyc();
    chk("t_load", {31'd0, slv_reg_wren}, 1);
    chk("t_data0", wdata, 0);
    repeat (TMO) cyc();
    chk("t_last_wait", {31'd0, slv_reg_wren}, 0);
    chk("t_last_busy", {31'd0, busy}, 1);
    cyc();
    chk("t_clr_wren", {31'd0, slv_reg_wren}, 1);
    chk("t_clr_addr", {29'd0, axi_awaddr}, 4);
    cyc();
    chk("t_done", {31'd0, done_valid}, 1);
    chk("t_done_to", {31'd0, done_timeout}, 1);
    chk("t_done_id", {30'd0, done_id}, 1);
    chk("t_done_ab", {31'd0, done_abort}, 0);
    cyc();

    // IRQ edge in the final WAIT cycle beats the timeout
    push1(2'd3, 32'd55);
    cyc();
    chk("e_load", {31'd0, slv_reg_wren}, 1);
    repeat (TMO) cyc();
    ext_irq = 1'b1;
    cyc();
    chk("e_clr", {31'd0, slv_reg_wren}, 1);
    ext_irq = 1'b0;
    cyc();
    chk("e_done", {31'd0, done_valid}, 1);
    chk("e_done_to", {31'd0, done_timeout}, 0);
    chk("e_done_id", {30'd0, done_id}, 3);
    cyc();

    // abort in WAIT with two jobs queued; concurrent request dropped
    push1(2'd1, 32'd7);
    push1(2'd2, 32'd8);
    push1(2'd3, 32'd9);
    chk("a_wait_lvl", {29'd0, q_level}, 2);
    chk("a_wait_busy", {31'd0, busy}, 1);
    abort = 1'b1; req_valid = 1'b1; req_id = 2'd0; req_data = 32'd99;
    #1;
    chk("a_ready_low", {31'd0, req_ready}, 0);
    cyc();
    abort = 1'b0; req_valid = 1'b0;
    chk("a_clr_wren", {31'd0, slv_reg_wren}, 1);
    chk("a_clr_addr", {29'd0, axi_awaddr}, 4);
    chk("a_lvl0", {29'd0, q_level}, 0);
    cyc();
    chk("a_done", {31'd0, done_valid}, 1);
    chk("a_done_ab", {31'd0, done_abort}, 1);
    chk("a_done_id", {30'd0, done_id}, 1);
    chk("a_done_to", {31'd0, done_timeout}, 0);
    seen = 0;
    repeat (10) begin
      cyc();
      if (slv_reg_wren) seen++;
    end
    chk("a_no_load", 32'(seen), 0);
    chk("a_idle", {31'd0, busy}, 0);

    // asynchronous reset mid-WAIT
    push1(2'd2, 32'd77);
    push1(2'd0, 32'd78);
    cyc(); cyc();
    chk("r_pre_busy", {31'd0, busy}, 1);
    chk("r_pre_lvl", {29'd0, q_level}, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("r_wren", {31'd0, slv_reg_wren}, 0);
    chk("r_busy", {31'd0, busy}, 0);
    chk("r_lvl", {29'd0, q_level}, 0);
    chk("r_ready", {31'd0, req_ready}, 0);
    chk("r_addr", {29'd0, axi_awaddr}, 0);
    chk("r_wdata", wdata, 0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    seen = 0;
    repeat (4) begin
      cyc();
      if (slv_reg_wren) seen++;
    end
    chk("r_no_stale", 32'(seen), 0);
    push1(2'd1, 32'd200);
    cyc();
    chk("r_load", {31'd0, slv_reg_wren}, 1);
    chk("r_load_data", wdata, 200);
    cyc(); cyc();
    ext_irq = 1'b1;
    cyc();
    chk("r_clr", {29'd0, axi_awaddr}, 4);
    ext_irq = 1'b0;
    cyc();
    chk("r_done", {31'd0, done_valid}, 1);
    chk("r_done_id", {30'd0, done_id}, 1);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/san_cnt_sched.md
# san_cnt_sched

Request scheduler that owns the san_cnt counter's register write port and shares it among queued timing jobs. Each accepted job carries a load value and a 2-bit tag. The scheduler programs the counter and waits for its EXT_IRQ rising edge or a timeout. It then clears the counter and reports completion with the tag. It sits between the software-facing job queue and the counter IP, inside the same S_AXI_ACLK domain.

## Interface
- DEPTH, 4, job FIFO entries (power of two, ≥2)
- TIMEOUT, 1000, WAIT-state cycle budget before a job is declared timed out (≥2)
- S_AXI_ACLK  in  1  clock, all logic rising-edge
- S_AXI_ARESET  in  1  reset, asynchronous, active-high
- req_valid  in  1  job offered
- req_ready  out  1  FIFO not full and abort low
- req_data  in  32  counter load value
- req_id  in  2  job tag
- abort  in  1  synchronous flush of queue and current job
- slv_reg_wren  out  1  counter register write strobe, one cycle per write
- axi_awaddr  out  3  counter register select: 3'd0 load/start, 3'd4 control
- S_AXI_WDATA  out  32  counter write data
- EXT_IRQ  in  1  counter completion interrupt, level
- done_valid  out  1  one-cycle completion pulse, no backpressure
- done_id  out  2  tag of completed job
- done_timeout  out  1  job ended by timeout
- done_abort  out  1  job ended by abort
- busy  out  1  state ≠ IDLE
- q_level  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Reset: state IDLE, FIFO empty, q_level 0, req_ready 0 while reset is asserted (1 afterwards), slv_reg_wren 0, axi_awaddr 0, S_AXI_WDATA 0, done_* 0, busy 0, irq_q 0, timer 0.
- FIFO: push on req_valid & req_ready. Pops happen only on the IDLE→LOAD transition. A push at full is impossible because ready is low.
- irq_edge = EXT_IRQ & ~irq_q. irq_q registers EXT_IRQ every cycle. Edges are acted on only in WAIT; in all other states they are ignored.
- FSM: IDLE→LOAD when q_level≠0 (pop, latch data and id); LOAD→WAIT; WAIT→CLEAR on irq_edge or timeout; CLEAR→REPORT; REPORT→IDLE.
- LOAD: slv_reg_wren=1, axi_awaddr=0, S_AXI_WDATA=latched value.
- WAIT: timer clears on entry and increments each cycle. Timeout fires when timer==TIMEOUT-1 with no edge. If an edge and the timeout coincide, the edge wins (done_timeout=0).
- CLEAR: slv_reg_wren=1, axi_awaddr=4, S_AXI_WDATA=0. This stops the counter and drops its IRQ.
- REPORT: done_valid=1, done_id=latched id, done_timeout/done_abort=latched flags. Flags clear on the next pop.
- Outside LOAD/CLEAR: slv_reg_wren=0; axi_awaddr/S_AXI_WDATA hold their last value.
- abort (any cycle): FIFO flushed and q_level=0 next cycle; req_ready=0 that cycle, so a concurrent request is dropped.
  - In LOAD or WAIT: go to CLEAR with done_abort=1, then REPORT.
  - In CLEAR or REPORT: the sequence finishes unchanged and done_abort keeps its latched value.
  - In IDLE: flush only, no report.
- Load value 0 is passed through unchanged; completion relies on the counter's IRQ or on the timeout.

## Timing
- Acceptance in cycle c into an empty idle block: the FIFO holds the job at c+1 (IDLE sees q_level=1), and LOAD strobe is in c+2.
- EXT_IRQ first sampled high in WAIT cycle k: CLEAR strobe at k+1, done_valid at k+2, IDLE at k+3. A queued next job reaches LOAD strobe at k+4.
- Timeout: the LOAD strobe is in cycle L. The last WAIT cycle is L+TIMEOUT, CLEAR at L+TIMEOUT+1, done_valid at L+TIMEOUT+2.
- Back-to-back job spacing, minimum: 5 cycles LOAD-to-LOAD (LOAD, WAIT≥1, CLEAR, REPORT, IDLE).
- Reset assertion mid-job: all outputs go to reset values immediately (asynchronous). No CLEAR write is issued.

## Test plan
- Single job: push data=100, id=2 → LOAD write addr0/data100 two cycles later. Raise EXT_IRQ 20 cycles after LOAD → CLEAR write addr4/data0 next cycle, then done_valid with id=2, timeout=0, abort=0.
- Queue fill: push ids 0..3 back-to-back while WAIT is held → ready low after the 4th outstanding entry (DEPTH=4). IRQ pulses complete the jobs in order 0,1,2,3, and q_level decrements on each pop.
- Timeout: TIMEOUT=8, no IRQ → done_valid 10 cycles after the LOAD strobe with done_timeout=1 and a CLEAR write preceding it.
- Edge vs timeout tie: raise EXT_IRQ exactly in the last WAIT cycle → done_timeout=0.
- Abort in WAIT with 2 jobs queued → CLEAR write, then done_valid with abort=1. q_level=0, no further LOAD, and a req_valid in the abort cycle is not accepted.
- Async reset asserted mid-WAIT → slv_reg_wren=0, busy=0, q_level=0 in the same cycle. After release, a new job runs normally.
